cpu_boot_loader: RTL and testbench
==================================

# cpu_boot_loader

Parametrised boot sequencer that holds the single-cycle CPU in reset while it preloads the register file and streams a program into instruction memory. Program words arrive through a valid/ready word stream. Once loading finishes, it zero-fills the unused instruction memory, waits a programmable hold time, and then releases the CPU. It sits between the top level and `cpu`, driving the register-file and IMem write ports and the CPU reset.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the instruction and register words.
- `IMEM_DEPTH`, 256: number of instruction-memory words. Must be a power of two and at least 2.
- `RF_DEPTH`, 32: number of registers.
- `RF_INIT_MODE`, 1: register-file initialisation.
  - 0: write zero to every register.
  - 1: write the register index to each register (reg i = i).
  - 2: skip register-file initialisation.
- `RESET_HOLD`, 4: number of cycles the CPU reset stays asserted after IMem fill ends. Must be at least 1.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reload`  in  1  one-cycle pulse; restarts the boot sequence from RF_INIT.
- `load_valid`  in  1  a program word is present on `load_data`.
- `load_data`  in  DATA_WIDTH  program word.
- `load_last`  in  1  marks the final program word.
- `load_ready`  out  1  high only in LOAD.
- `imem_we`  out  1  IMem write strobe.
- `imem_addr`  out  $clog2(IMEM_DEPTH)  IMem word address.
- `imem_wdata`  out  DATA_WIDTH  IMem write data.
- `rf_we`  out  1  register-file write strobe.
- `rf_addr`  out  $clog2(RF_DEPTH)  register address.
- `rf_wdata`  out  DATA_WIDTH  register write data.
- `cpu_reset`  out  1  active-low reset to `cpu`; 1 releases the CPU.
- `done`  out  1  boot complete; equal to `cpu_reset`.
- `overflow`  out  1  sticky flag: IMem filled before `load_last` arrived.

## Operation
- FSM states: RF_INIT, LOAD, FILL, HOLD, RUN.
- Reset values:
  - State = RF_INIT.
  - All outputs = 0, including `cpu_reset` = 0 and `overflow` = 0.
  - All counters = 0.
- RF_INIT:
  - One register write per cycle, addresses 0 to RF_DEPTH-1.
  - `rf_wdata` is 0 or the index, per `RF_INIT_MODE`.
  - Goes to LOAD after address RF_DEPTH-1 is written.
  - With mode 2, the FSM moves to LOAD on the first clock with no writes.
- LOAD:
  - A word is accepted on a cycle where `load_valid` and `load_ready` are both high.
  - Each accepted word is written to the next word address, starting at 0.
  - On accepting a word with `load_last`=1, go to FILL.
  - On accepting address IMEM_DEPTH-1 with `load_last`=0, set `overflow`=1 and go to HOLD.
  - Zero words accepted is allowed; the loader stays in LOAD indefinitely.
- FILL:
  - Writes 0 to every remaining address, one per cycle, up to IMEM_DEPTH-1, then goes to HOLD.
  - If `load_last` arrived on address IMEM_DEPTH-1, FILL performs no writes and the FSM goes straight to HOLD.
- HOLD: counts RESET_HOLD cycles, then goes to RUN.
- RUN: `cpu_reset`=1 and `done`=1; the loader stays in RUN until `reload`.
- `reload`:
  - Accepted in any state.
  - Next cycle: state = RF_INIT, counters cleared, `cpu_reset`=0, `overflow` cleared.
  - Any in-flight accepted word is discarded: its write strobe is suppressed.
- Asynchronous `reset` mid-sequence behaves exactly like power-on reset.

## Timing
- All outputs are registered except `load_ready`, which is combinational from state: `load_ready` = (state == LOAD).
- A word accepted at edge t produces `imem_we`/`imem_addr`/`imem_wdata` valid during cycle t+1, for exactly one cycle.
- `rf_we` and `imem_we` are never high in the same cycle.
- Back-to-back acceptance is sustained at 1 word per cycle; there are no bubbles.
- Boot latency from `load_last` acceptance to `cpu_reset` rising = (IMEM_DEPTH-1-last_addr) + RESET_HOLD + 1 cycles.
- Address counters use the widths listed above. A counter never wraps past its depth: the terminal address forces the state transition.

## Structure
- The shared package `boot_pkg` holds:
  - the state enum;
  - the `RF_INIT_MODE` constants (`RF_ZERO`, `RF_INDEX`, `RF_SKIP`).
- Address-width helper localparams stay inside the module.
- One sub-module, `boot_hold_counter`, implements the RESET_HOLD down-counter: load, count, expire pulse.
- Everything else is a single FSM plus two address counters.

## Test plan
- Default parameters, 3 words 0x11, 0x22, 0x33 with `last` on the third:
  - RF writes i→i for i=0..31.
  - IMem writes 0..2 with those words.
  - Zero writes to addresses 3..255.
  - `cpu_reset` rises 253+4+1 cycles after the third word is accepted.
  - `overflow`=0.
- `load_valid` toggling every other cycle: exactly one IMem write per accepted word, at consecutive addresses, with no duplicates or drops.
- IMEM_DEPTH=8, 9 words with no `last`:
  - 8 writes.
  - `overflow`=1 after the 8th word.
  - `load_ready` drops.
  - `cpu_reset`=1 after 5 cycles.
- `RF_INIT_MODE`=2: no `rf_we` pulse, and `load_ready` is high on the first clock after reset release.
- `reload` pulse in RUN, then a 1-word program:
  - `cpu_reset` falls the next cycle.
  - The RF is reinitialised.
  - The new word is at address 0.
  - `overflow` is cleared.
- `reset` asserted mid-FILL: all outputs go to 0 immediately (asynchronous), and the sequence restarts at RF_INIT on release.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared boot-sequencer types: FSM state encoding and register-file init modes.
package boot_pkg;

    typedef enum logic [2:0] {
        S_RF_INIT,
        S_LOAD,
        S_FILL,
        S_HOLD,
        S_RUN
    } boot_state_e;

    localparam int RF_ZERO  = 0;
    localparam int RF_INDEX = 1;
    localparam int RF_SKIP  = 2;

endpackage

// File: rtl/boot_hold_counter.sv
// Down-counter for the CPU reset hold window; expire marks the last HOLD cycle.
module boot_hold_counter #(
    parameter int HOLD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(HOLD);
        else if (en && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign expire = en && (cnt == CW'(1));

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot sequencer: preloads the RF, streams the program into IMem, zero-fills the
// remainder, holds the CPU in reset for RESET_HOLD cycles, then releases it.
module cpu_boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int IMEM_DEPTH   = 256,
    parameter int RF_DEPTH     = 32,
    parameter int RF_INIT_MODE = 1,
    parameter int RESET_HOLD   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          reload,
    input  logic                          load_valid,
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]         imem_wdata,
    output logic                          rf_we,
    output logic [$clog2(RF_DEPTH)-1:0]   rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    output logic                          cpu_reset,
    output logic                          done,
    output logic                          overflow
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int RAW = $clog2(RF_DEPTH);
    localparam logic [IAW-1:0] IMEM_LAST = IAW'(IMEM_DEPTH - 1);
    localparam logic [RAW-1:0] RF_LAST   = RAW'(RF_DEPTH - 1);

    boot_state_e    state;
    logic [IAW-1:0] iaddr;
    logic [RAW-1:0] rf_cnt;
    logic           hold_expire;

    // Counter reloads whenever we are outside HOLD, so every HOLD entry starts fresh.
    boot_hold_counter #(.HOLD(RESET_HOLD)) u_hold (
        .clock  (clock),
        .reset  (reset),
        .load   (state != S_HOLD),
        .en     (state == S_HOLD),
        .expire (hold_expire)
    );

    assign load_ready = (state == S_LOAD);
    assign done       = cpu_reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_RF_INIT;
            iaddr      <= '0;
            rf_cnt     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            cpu_reset  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            rf_we   <= 1'b0;
            if (reload) begin
                // Strobes stay low here, so a word handshaked on this edge is dropped.
                state      <= S_RF_INIT;
                iaddr      <= '0;
                rf_cnt     <= '0;
                imem_addr  <= '0;
                imem_wdata <= '0;
                rf_addr    <= '0;
                rf_wdata   <= '0;
                cpu_reset  <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                case (state)
                    S_RF_INIT: begin
                        if (RF_INIT_MODE == RF_SKIP) begin
                            state <= S_LOAD;
                        end else begin
                            rf_we    <= 1'b1;
                            rf_addr  <= rf_cnt;
                            rf_wdata <= (RF_INIT_MODE == RF_INDEX) ? DATA_WIDTH'(rf_cnt) : '0;
                            if (rf_cnt == RF_LAST) begin
                                rf_cnt <= '0;
                                state  <= S_LOAD;
                            end else begin
                                rf_cnt <= rf_cnt + RAW'(1);
                            end
                        end
                    end
                    S_LOAD: begin
                        if (load_valid) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= iaddr;
                            imem_wdata <= load_data;
                            if (iaddr == IMEM_LAST) begin
                                // Memory full: nothing left to fill either way.
                                state <= S_HOLD;
                                if (!load_last)
                                    overflow <= 1'b1;
                            end else begin
                                iaddr <= iaddr + IAW'(1);
                                if (load_last)
                                    state <= S_FILL;
                            end
                        end
                    end
                    S_FILL: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= iaddr;
                        imem_wdata <= '0;
                        if (iaddr == IMEM_LAST)
                            state <= S_HOLD;
                        else
                            iaddr <= iaddr + IAW'(1);
                    end
                    S_HOLD: begin
                        if (hold_expire)
                            state <= S_RUN;
                    end
                    S_RUN: begin
                        cpu_reset <= 1'b1;
                    end
                    default: state <= S_RF_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Two loader instances (default and a small skip-RF/8-word one) checked against a
// write-log model built from the boot rules.
module tb_cpu_boot_loader;
    localparam int DW = 32;
    localparam int H  = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]         rl, lv, ll;
    logic [1:0][DW-1:0] ld;
    wire  [1:0]         lr, iwe, rwe, cr, dn, ov;
    wire  [1:0][DW-1:0] iwd, rwd;
    wire  [7:0]         ia0;
    wire  [2:0]         ia1;
    wire  [4:0]         ra0;
    wire  [1:0]         ra1;
    wire  [1:0][7:0]    ia;
    wire  [1:0][4:0]    ra;
    assign ia[0] = ia0;
    assign ia[1] = {5'b0, ia1};
    assign ra[0] = ra0;
    assign ra[1] = {3'b0, ra1};

    cpu_boot_loader #(.DATA_WIDTH(DW), .IMEM_DEPTH(256), .RF_DEPTH(32),
                      .RF_INIT_MODE(1), .RESET_HOLD(H)) dut0 (
        .clock(clock), .reset(reset), .reload(rl[0]), .load_valid(lv[0]),
        .load_data(ld[0]), .load_last(ll[0]), .load_ready(lr[0]), .imem_we(iwe[0]),
        .imem_addr(ia0), .imem_wdata(iwd[0]), .rf_we(rwe[0]), .rf_addr(ra0),
        .rf_wdata(rwd[0]), .cpu_reset(cr[0]), .done(dn[0]), .overflow(ov[0]));

    cpu_boot_loader #(.DATA_WIDTH(DW), .IMEM_DEPTH(8), .RF_DEPTH(4),
                      .RF_INIT_MODE(2), .RESET_HOLD(H)) dut1 (
        .clock(clock), .reset(reset), .reload(rl[1]), .load_valid(lv[1]),
        .load_data(ld[1]), .load_last(ll[1]), .load_ready(lr[1]), .imem_we(iwe[1]),
        .imem_addr(ia1), .imem_wdata(iwd[1]), .rf_we(rwe[1]), .rf_addr(ra1),
        .rf_wdata(rwd[1]), .cpu_reset(cr[1]), .done(dn[1]), .overflow(ov[1]));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]    log_a [2][256];
    logic [DW-1:0] log_d [2][256];
    int            log_n [2];
    logic [DW-1:0] rf_seen [2][32];
    int            rf_cnt [2];
    logic          cr_prev [2];
    int            rise_cyc [2];
    logic [DW-1:0] wr [2][256];
    int            nacc [2];
    int            t_last [2];

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 8;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Write logger: the model state is the ordered list of writes each DUT makes.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("done_eq_cpu_reset%0d", k), dn[k], cr[k]);
            chk($sformatf("we_exclusive%0d", k), rwe[k] & iwe[k], 0);
            if (rwe[k]) begin
                rf_seen[k][ra[k]] = rwd[k];
                rf_cnt[k]++;
            end
            if (iwe[k]) begin
                if (log_n[k] < 256) begin
                    log_a[k][log_n[k]] = ia[k];
                    log_d[k][log_n[k]] = iwd[k];
                end
                log_n[k]++;
            end
            if (cr[k] && !cr_prev[k]) rise_cyc[k] = cyc;
            cr_prev[k] = cr[k];
        end
    end

    task automatic clear_logs(input int k);
        log_n[k]    = 0;
        rf_cnt[k]   = 0;
        rise_cyc[k] = -1;
        for (int i = 0; i < 32; i++) rf_seen[k][i] = 32'hDEAD_BEEF;
    endtask

    task automatic check_idle(input int k, input string tag);
        chk({tag, "_cpu_reset"}, cr[k], 0);
        chk({tag, "_done"}, dn[k], 0);
        chk({tag, "_overflow"}, ov[k], 0);
        chk({tag, "_imem_we"}, iwe[k], 0);
        chk({tag, "_rf_we"}, rwe[k], 0);
        chk({tag, "_load_ready"}, lr[k], 0);
        chk({tag, "_imem_addr"}, ia[k], 0);
        chk({tag, "_rf_addr"}, ra[k], 0);
        chk({tag, "_imem_wdata"}, iwd[k], 0);
        chk({tag, "_rf_wdata"}, rwd[k], 0);
    endtask

    // vmode: 0 valid always, 1 every other cycle, 2 random. base!=0 gives base*(i+1) data.
    task automatic drive_prog(input int k, input int n, input bit has_last,
                              input int vmode, input logic [DW-1:0] base);
        int acc = 0;
        int g = 0;
        int want;
        bit ph = 1'b1;
        bit v;
        want = has_last ? n : ((n < dep(k)) ? n : dep(k));
        while (acc < want && g < 4000) begin
            @(negedge clock); #1;
            case (vmode)
                0: v = 1'b1;
                1: begin v = ph; ph = ~ph; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            lv[k] = v;
            ld[k] = (base != '0) ? base * DW'(acc + 1) : DW'($urandom);
            ll[k] = has_last && (acc == n - 1);
            if (v && lr[k]) begin
                wr[k][acc] = ld[k];
                t_last[k]  = cyc + 1;
                acc++;
            end
            g++;
        end
        chk($sformatf("accepted_words%0d", k), acc, want);
        nacc[k] = acc;
        @(negedge clock); #1;
        lv[k] = 1'b0;
        ll[k] = 1'b0;
    endtask

    task automatic finish_prog(input int k, input bit has_last);
        int g = 0;
        int nlog;
        while (!cr[k] && g < 2000) begin
            @(negedge clock);
            g++;
        end
        #1;
        chk($sformatf("boot_reached%0d", k), cr[k], 1);
        chk($sformatf("boot_latency%0d", k), rise_cyc[k] - t_last[k],
            (dep(k) - nacc[k]) + H + 1);
        chk($sformatf("overflow%0d", k), ov[k], !has_last);
        chk($sformatf("imem_writes%0d", k), log_n[k], dep(k));
        nlog = (log_n[k] < 256) ? log_n[k] : 256;
        for (int i = 0; i < nlog; i++) begin
            chk($sformatf("imem_addr%0d[%0d]", k, i), log_a[k][i], i);
            chk($sformatf("imem_data%0d[%0d]", k, i), log_d[k][i],
                (i < nacc[k]) ? wr[k][i] : '0);
        end
        if (k == 0) begin
            chk("rf_writes0", rf_cnt[0], 32);
            for (int i = 0; i < 32; i++)
                chk($sformatf("rf_data0[%0d]", i), rf_seen[0][i], i);
        end else begin
            chk("rf_writes1", rf_cnt[1], 0);
        end
    endtask

    task automatic reload_pulse(input int k);
        @(negedge clock); #1;
        rl[k] = 1'b1;
        clear_logs(k);
        @(negedge clock);
        chk($sformatf("reload_cpu_reset%0d", k), cr[k], 0);
        chk($sformatf("reload_overflow%0d", k), ov[k], 0);
        chk($sformatf("reload_imem_we%0d", k), iwe[k], 0);
        #1;
        rl[k] = 1'b0;
    endtask

    initial begin
        int g;
        rl = '0; lv = '0; ll = '0; ld = '0;
        for (int k = 0; k < 2; k++) begin
            clear_logs(k);
            cr_prev[k] = 1'b0;
            nacc[k] = 0;
            t_last[k] = 0;
        end
        repeat (2) @(negedge clock);
        #1;
        check_idle(0, "por0");
        check_idle(1, "por1");
        reset = 1'b1;
        @(negedge clock);
        chk("skip_ready_first_clock", lr[1], 1);
        chk("skip_no_rf_we", rwe[1], 0);
        chk("rf_first_we", rwe[0], 1);
        chk("rf_first_addr", ra[0], 0);

        // Default config, 0x11/0x22/0x33 with last on the third word.
        drive_prog(0, 3, 1'b1, 0, 32'h11);
        finish_prog(0, 1'b1);

        // Small config overflow: 9 words offered, no last.
        drive_prog(1, 9, 1'b0, 2, '0);
        chk("overflow_ready_drop", lr[1], 0);
        chk("overflow_set", ov[1], 1);
        finish_prog(1, 1'b0);

        // Reload in RUN, then a one-word program with toggling valid.
        chk("run_before_reload", cr[0], 1);
        reload_pulse(0);
        drive_prog(0, 1, 1'b1, 1, '0);
        finish_prog(0, 1'b1);

        reload_pulse(1);
        drive_prog(1, 5, 1'b1, 1, '0);
        finish_prog(1, 1'b1);

        // Last word lands on the final address: no fill phase.
        reload_pulse(1);
        drive_prog(1, 8, 1'b1, 2, '0);
        finish_prog(1, 1'b1);

        // Reload while a word is being handshaked: its write must vanish.
        reload_pulse(0);
        g = 0;
        while (!lr[0] && g < 100) begin
            @(negedge clock); #1;
            g++;
        end
        chk("reach_load", lr[0], 1);
        for (int j = 0; j < 3; j++) begin
            lv[0] = 1'b1;
            ld[0] = $urandom;
            @(negedge clock); #1;
        end
        rl[0] = 1'b1;
        ld[0] = $urandom;
        clear_logs(0);
        @(negedge clock);
        chk("reload_suppress_we", iwe[0], 0);
        chk("reload_ready_low", lr[0], 0);
        #1;
        rl[0] = 1'b0;
        lv[0] = 1'b0;
        drive_prog(0, $urandom_range(2, 40), 1'b1, 2, '0);
        finish_prog(0, 1'b1);

        // Asynchronous reset in the middle of FILL.
        reload_pulse(0);
        drive_prog(0, 2, 1'b1, 0, '0);
        repeat (5) @(negedge clock);
        chk("in_fill", iwe[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check_idle(0, "async0");
        check_idle(1, "async1");
        clear_logs(0);
        clear_logs(1);
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("restart_rf_we", rwe[0], 1);
        chk("restart_rf_addr", ra[0], 0);
        chk("restart_skip_ready", lr[1], 1);
        drive_prog(0, $urandom_range(1, 60), 1'b1, 0, '0);
        finish_prog(0, 1'b1);
        drive_prog(1, 3, 1'b1, 2, '0);
        finish_prog(1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
